// File: rtl/div_pipe_param.sv
// div_pipe_param: fully pipelined restoring integer divider with tag passthrough
// and a single global stall enable driven by output backpressure.
module div_pipe_param #(
  parameter int WIDTH = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int SIGNED = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int N = WIDTH / BITS_PER_STAGE;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  if ((BITS_PER_STAGE != 1 && BITS_PER_STAGE != 2) || (WIDTH % BITS_PER_STAGE) != 0) begin : g_bad
    $error("div_pipe_param: BITS_PER_STAGE must be 1 or 2 and divide WIDTH");
  end
  logic             en, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             v_q   [0:N];
  logic [WIDTH-1:0] a_q   [0:N];
  logic [WIDTH-1:0] r_q   [0:N];
  logic [WIDTH-1:0] d_q   [0:N-1];
  logic             qs_q  [0:N];
  logic             rs_q  [0:N];
  logic             dbz_q [0:N];
  logic             ovf_q [0:N];
  logic [TAG_W-1:0] tag_q [0:N];
  logic [WIDTH-1:0] a_n   [1:N];
  logic [WIDTH-1:0] r_n   [1:N];
  logic [WIDTH-1:0] a_t, r_t;
  logic [WIDTH:0]   c_t, df_t;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign neg_a    = (SIGNED != 0) && dividend[WIDTH-1];
  assign neg_b    = (SIGNED != 0) && divisor[WIDTH-1];
  assign mag_a    = neg_a ? -dividend : dividend;
  assign mag_b    = neg_b ? -divisor : divisor;
  // a_q shifts dividend bits out of its MSB while quotient bits enter at its LSB;
  // the shifted partial remainder c_t is WIDTH+1 bits and df_t[WIDTH] is the borrow.
  always_comb begin
    a_t  = '0;
    r_t  = '0;
    c_t  = '0;
    df_t = '0;
    for (int s = 1; s <= N; s++) begin
      a_t = a_q[s-1];
      r_t = r_q[s-1];
      for (int i = 0; i < BITS_PER_STAGE; i++) begin
        c_t  = {r_t, a_t[WIDTH-1]};
        df_t = c_t - {1'b0, d_q[s-1]};
        a_t  = {a_t[WIDTH-2:0], !df_t[WIDTH]};
        r_t  = df_t[WIDTH] ? c_t[WIDTH-1:0] : df_t[WIDTH-1:0];
      end
      a_n[s] = a_t;
      r_n[s] = r_t;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= N; s++) v_q[s] <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      out_tag     <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (en) begin
      v_q[0]   <= in_valid;
      a_q[0]   <= mag_a;
      r_q[0]   <= '0;
      d_q[0]   <= mag_b;
      qs_q[0]  <= neg_a ^ neg_b;
      rs_q[0]  <= neg_a;
      dbz_q[0] <= divisor == '0;
      ovf_q[0] <= (SIGNED != 0) && dividend == MIN && divisor == '1;
      tag_q[0] <= in_tag;
      for (int s = 1; s <= N; s++) begin
        v_q[s]   <= v_q[s-1];
        a_q[s]   <= a_n[s];
        r_q[s]   <= r_n[s];
        qs_q[s]  <= qs_q[s-1];
        rs_q[s]  <= rs_q[s-1];
        dbz_q[s] <= dbz_q[s-1];
        ovf_q[s] <= ovf_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
      for (int s = 1; s < N; s++) d_q[s] <= d_q[s-1];
      // a zero divisor leaves the dividend magnitude in the remainder, so re-signing restores the raw dividend
      out_valid   <= v_q[N];
      quotient    <= dbz_q[N] ? '1 : qs_q[N] ? -a_q[N] : a_q[N];
      remainder   <= rs_q[N] ? -r_q[N] : r_q[N];
      out_tag     <= tag_q[N];
      div_by_zero <= dbz_q[N];
      overflow    <= ovf_q[N];
    end
  end
endmodule

// File: tb/tb_div_pipe_param.sv
// tb_div_pipe_param: two 16-bit dividers (signed/1 bit per stage, unsigned/2 bits per stage)
// checked against a plain-arithmetic reference with an in-order scoreboard.
module tb_div_pipe_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        in_valid [2], in_ready [2], out_valid [2], out_ready [2];
  logic        div_by_zero [2], overflow [2];
  logic [15:0] dividend [2], divisor [2], quotient [2], remainder [2];
  logic [3:0]  in_tag [2], out_tag [2];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [37:0] expq [2][$];
  logic        hold_pend [2] = '{1'b0, 1'b0};
  logic [37:0] hold_val [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    div_pipe_param #(.WIDTH(16), .BITS_PER_STAGE(g + 1), .SIGNED(1 - g), .TAG_W(4)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .dividend(dividend[g]), .divisor(divisor[g]), .in_tag(in_tag[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .quotient(quotient[g]), .remainder(remainder[g]), .out_tag(out_tag[g]),
      .div_by_zero(div_by_zero[g]), .overflow(overflow[g])
    );
  end

  // {dbz, ovf, quotient, remainder} straight from the arithmetic rules
  function automatic logic [33:0] ref_div(bit sgn, logic [15:0] a, logic [15:0] b);
    int sa, sb, q, r;
    if (b == 16'h0) return {2'b10, 16'hFFFF, a};
    if (sgn && a == 16'h8000 && b == 16'hFFFF) return {2'b01, 16'h8000, 16'h0000};
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    q = sa / sb;
    r = sa % sb;
    return {2'b00, q[15:0], r[15:0]};
  endfunction

  function automatic logic [37:0] cur(int g);
    return {out_tag[g], div_by_zero[g], overflow[g], quotient[g], remainder[g]};
  endfunction

  function automatic logic [15:0] pick_b();
    int k = $urandom_range(0, 7);
    return k == 0 ? 16'h0 : k == 1 ? 16'hFFFF : k == 2 ? 16'($urandom_range(1, 15)) : 16'($urandom);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        expq[g].delete();
        hold_pend[g] = 1'b0;
      end else begin
        if (hold_pend[g]) begin
          chk($sformatf("hold_valid%0d", g), 64'(out_valid[g]), 64'd1);
          chk($sformatf("hold_data%0d", g), 64'(cur(g)), 64'(hold_val[g]));
        end
        chk($sformatf("in_ready%0d", g), 64'(in_ready[g]), 64'(!(out_valid[g] && !out_ready[g])));
        if (out_valid[g] && out_ready[g]) begin
          if (expq[g].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ghost_result%0d: got %0h expected no result", g, cur(g));
          end else begin
            chk($sformatf("result%0d", g), 64'(cur(g)), 64'(expq[g].pop_front()));
          end
        end
        hold_pend[g] = out_valid[g] && !out_ready[g];
        hold_val[g]  = cur(g);
        if (in_valid[g] && in_ready[g])
          expq[g].push_back({in_tag[g], ref_div(g == 0, dividend[g], divisor[g])});
      end
    end
  end

  task automatic run1(int g, logic [15:0] a, logic [15:0] b, logic [3:0] t,
                      logic [15:0] eq, logic [15:0] er, logic ed, logic eo);
    int cnt = 0;
    bit ok = 1'b0;
    chk($sformatf("model_%0h_%0h", a, b), 64'(ref_div(g == 0, a, b)), 64'({ed, eo, eq, er}));
    @(posedge clk);
    #1;
    in_valid[g] = 1'b1; dividend[g] = a; divisor[g] = b; in_tag[g] = t; out_ready[g] = 1'b1;
    while (!ok && cnt < 40) begin
      @(posedge clk);
      cnt++;
      #1 in_valid[g] = 1'b0;
      @(negedge clk);
      ok = out_valid[g];
    end
    chk($sformatf("latency%0d", g), 64'(cnt), g == 0 ? 64'd18 : 64'd10);
    chk("quotient", 64'(quotient[g]), 64'(eq));
    chk("remainder", 64'(remainder[g]), 64'(er));
    chk("out_tag", 64'(out_tag[g]), 64'(t));
    chk("div_by_zero", 64'(div_by_zero[g]), 64'(ed));
    chk("overflow", 64'(overflow[g]), 64'(eo));
  endtask

  task automatic stream(int g);
    int i = 0;
    int budget = 0;
    bit acc;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b1;
    dividend[g] = 16'($urandom); divisor[g] = pick_b(); in_tag[g] = 4'd0;
    out_ready[g] = 1'($urandom_range(0, 1));
    while (i < 200 && budget < 5000) begin
      @(negedge clk);
      acc = in_ready[g];
      @(posedge clk);
      #1;
      budget++;
      if (acc) begin
        i++;
        dividend[g] = $urandom_range(0, 9) == 0 ? 16'h8000 : 16'($urandom);
        divisor[g]  = pick_b();
        in_tag[g]   = 4'(i % 16);
      end
      if (i == 200) in_valid[g] = 1'b0;
      out_ready[g] = 1'($urandom_range(0, 1));
    end
    chk($sformatf("stream_issued%0d", g), 64'(i), 64'd200);
    in_valid[g] = 1'b0;
    out_ready[g] = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk($sformatf("drained%0d", g), 64'(expq[g].size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ghost;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0; out_ready[g] = 1'b1;
      dividend[g] = '0; divisor[g] = 16'd1; in_tag[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_out_valid", 64'(out_valid[g]), 64'd0);
      chk("rst_quotient", 64'(quotient[g]), 64'd0);
      chk("rst_remainder", 64'(remainder[g]), 64'd0);
      chk("rst_flags_tag", 64'({div_by_zero[g], overflow[g], out_tag[g]}), 64'd0);
      chk("rst_in_ready", 64'(in_ready[g]), 64'd1);
    end
    run1(0, 16'd100,  16'd7,    4'd3, 16'd14,   16'd2,    1'b0, 1'b0);
    run1(0, 16'hFF9C, 16'd7,    4'd5, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
    run1(0, 16'd100,  16'hFFF9, 4'd6, 16'hFFF2, 16'h0002, 1'b0, 1'b0);
    run1(0, 16'd5,    16'd0,    4'd7, 16'hFFFF, 16'd5,    1'b1, 1'b0);
    run1(0, 16'h8000, 16'hFFFF, 4'd8, 16'h8000, 16'h0000, 1'b0, 1'b1);
    run1(1, 16'hFFFF, 16'h0003, 4'd9, 16'h5555, 16'h0000, 1'b0, 1'b0);
    run1(1, 16'h8000, 16'hFFFF, 4'd10, 16'h0000, 16'h8000, 1'b0, 1'b0);
    stream(0);
    stream(1);
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid[0] = 1'b1; dividend[0] = 16'(1000 + k); divisor[0] = 16'(k + 3); in_tag[0] = 4'(k);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_outputs", 64'(cur(0)), 64'd0);
    ghost = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid[0]) ghost++;
    end
    chk("no_ghost", 64'(ghost), 64'd0);
    run1(0, 16'd1000, 16'd3, 4'd2, 16'd333, 16'd1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
